if_fetch_stage: RTL and testbench

Instruction-fetch stage of the single-issue RV64 core, directly upstream of decode and therefore of the execute stage.
- Holds the architectural PC and fetches one 32-bit instruction per step over a req/gnt/rvalid instruction-memory port.
- Presents the instruction and its PC to decode with a valid/ready handshake.
- Waits for execute to return the resolved next PC before fetching again; the core is non-pipelined, so one instruction is in flight at a time.

---
 rtl/if_fetch_stage_pkg.sv | 22 ++
 rtl/if_fetch_stage.sv | 126 ++++++++++++
 tb/tb_if_fetch_stage.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Reset values, the NOP word and the fetch FSM encoding live here.
package if_fetch_stage_pkg;

    localparam logic [63:0] ZERO_WORD    = 64'h0;
    localparam logic        RST_ENABLE   = 1'b1;

    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT_R  = 2'd1,
        S_OUT     = 2'd2,
        S_WAIT_PC = 2'd3
    } fetch_state_e;

    function automatic logic pc_misaligned(input logic [63:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction fetch for the non-pipelined RV64 core.
// One instruction in flight: fetch, hand to decode, wait for next PC.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] next_pc_i,
    input  logic        next_pc_valid_i,
    output logic        inst_req_o,
    output logic [63:0] inst_addr_o,
    input  logic        inst_gnt_i,
    input  logic        inst_rvalid_i,
    input  logic [31:0] inst_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o,
    output logic        fault_o,
    output logic [63:0] fetch_cnt_o
);

    fetch_state_e r_state;
    logic [63:0]  r_pc;
    logic         r_valid;
    logic [31:0]  r_inst;
    logic [63:0]  r_pc_out;
    logic         r_fault;
    logic [63:0]  r_cnt;

    logic w_misaligned;
    logic w_handshake;
    logic w_redirect;

    assign w_misaligned = pc_misaligned(r_pc);
    assign w_handshake  = (r_state == S_OUT) && inst_ready_i;
    // A redirect is only honoured at the handshake or while waiting for it.
    assign w_redirect   = next_pc_valid_i &&
                          (w_handshake || (r_state == S_WAIT_PC));

    assign inst_req_o   = (r_state == S_FETCH) && !w_misaligned;
    assign inst_addr_o  = r_pc;
    assign inst_valid_o = r_valid;
    assign inst_o       = r_inst;
    assign pc_o         = r_pc_out;
    assign fault_o      = r_fault;
    assign fetch_cnt_o  = r_cnt;

    // FSM state and architectural PC.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (w_misaligned) begin
                        r_state <= S_OUT;
                    end else if (inst_gnt_i) begin
                        r_state <= S_WAIT_R;
                    end
                end
                S_WAIT_R: begin
                    if (inst_rvalid_i) begin
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (w_handshake) begin
                        r_state <= w_redirect ? S_FETCH : S_WAIT_PC;
                    end
                end
                S_WAIT_PC: begin
                    if (w_redirect) begin
                        r_state <= S_FETCH;
                    end
                end
            endcase
            if (w_redirect) begin
                r_pc <= next_pc_i;
            end
        end
    end

    // Registered decode-side outputs and the hand-off counter.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_valid  <= 1'b0;
            r_inst   <= NOP_INST;
            r_pc_out <= ZERO_WORD;
            r_fault  <= 1'b0;
            r_cnt    <= ZERO_WORD;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (w_misaligned) begin
                        r_valid  <= 1'b1;
                        r_inst   <= NOP_INST;
                        r_pc_out <= r_pc;
                        r_fault  <= 1'b1;
                    end
                end
                S_WAIT_R: begin
                    if (inst_rvalid_i) begin
                        r_valid  <= 1'b1;
                        r_inst   <= inst_rdata_i;
                        r_pc_out <= r_pc;
                        r_fault  <= 1'b0;
                    end
                end
                S_OUT: begin
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        r_cnt   <= r_cnt + 64'd1;
                    end
                end
                S_WAIT_PC: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised bench for if_fetch_stage against a per-instruction
// transaction model (expected PC, expected word, hand-off count).
module tb_if_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] next_pc_i;
    logic        next_pc_valid_i;
    logic        inst_req_o;
    logic [63:0] inst_addr_o;
    logic        inst_gnt_i;
    logic        inst_rvalid_i;
    logic [31:0] inst_rdata_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        fault_o;
    logic [63:0] fetch_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] m_pc;
    logic [63:0] m_cnt;

    if_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .next_pc_i       (next_pc_i),
        .next_pc_valid_i (next_pc_valid_i),
        .inst_req_o      (inst_req_o),
        .inst_addr_o     (inst_addr_o),
        .inst_gnt_i      (inst_gnt_i),
        .inst_rvalid_i   (inst_rvalid_i),
        .inst_rdata_i    (inst_rdata_i),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_o          (inst_o),
        .pc_o            (pc_o),
        .fault_o         (fault_o),
        .fetch_cnt_o     (fetch_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ {a[63:32] ^ 32'h5A5A_C3C3} ^ 32'h0000_0093;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] ei,
                             input logic [63:0] ep, input logic ef);
        check_eq({tag, ".valid"}, 64'(inst_valid_o), 64'd1);
        check_eq({tag, ".inst"},  64'(inst_o), 64'(ei));
        check_eq({tag, ".pc"},    pc_o, ep);
        check_eq({tag, ".fault"}, 64'(fault_o), 64'(ef));
    endtask

    // One full instruction: fetch at m_pc, hand off, redirect to tgt.
    task automatic do_fetch(input int gd, input int rd, input int yd,
                            input bit same, input int wd,
                            input logic [63:0] tgt, input bit spur);
        logic        mis;
        logic [31:0] ei;
        mis = (m_pc[1:0] != 2'b00);
        ei  = mis ? NOP : mem_word(m_pc);
        check_eq("fetch.addr", inst_addr_o, m_pc);
        if (mis) begin
            check_eq("mis.req", 64'(inst_req_o), 64'd0);
            step();
        end else begin
            for (int i = 0; i < gd; i++) begin
                check_eq("stall.req", 64'(inst_req_o), 64'd1);
                check_eq("stall.addr", inst_addr_o, m_pc);
                step();
            end
            check_eq("gnt.req", 64'(inst_req_o), 64'd1);
            inst_gnt_i = 1'b1;
            step();
            inst_gnt_i = 1'b0;
            for (int i = 0; i < rd; i++) begin
                check_eq("waitr.valid", 64'(inst_valid_o), 64'd0);
                next_pc_valid_i = spur && (i == 0);
                next_pc_i       = 64'(~m_pc);
                step();
                next_pc_valid_i = 1'b0;
            end
            inst_rvalid_i = 1'b1;
            inst_rdata_i  = ei;
            step();
            inst_rvalid_i = 1'b0;
            inst_rdata_i  = 32'($urandom);
        end
        for (int i = 0; i < yd; i++) begin
            check_out("hold", ei, m_pc, mis);
            step();
        end
        check_out("hs", ei, m_pc, mis);
        inst_ready_i    = 1'b1;
        next_pc_valid_i = same;
        next_pc_i       = tgt;
        step();
        inst_ready_i    = 1'b0;
        next_pc_valid_i = 1'b0;
        m_cnt           = m_cnt + 64'd1;
        check_eq("post.valid", 64'(inst_valid_o), 64'd0);
        check_eq("post.cnt", fetch_cnt_o, m_cnt);
        if (!same) begin
            for (int i = 0; i < wd; i++) begin
                check_eq("waitpc.req", 64'(inst_req_o), 64'd0);
                inst_rvalid_i = spur;
                inst_rdata_i  = 32'($urandom);
                step();
                inst_rvalid_i = 1'b0;
                check_eq("waitpc.valid", 64'(inst_valid_o), 64'd0);
            end
            next_pc_valid_i = 1'b1;
            next_pc_i       = tgt;
            step();
            next_pc_valid_i = 1'b0;
        end
        m_pc = tgt;
    endtask

    function automatic logic [63:0] rand_target();
        int          k;
        logic [63:0] t;
        k = int'($urandom_range(0, 9));
        t = RST_PC + 64'({$urandom_range(0, 1023), 2'b00});
        if (k == 0) t[1:0] = 2'($urandom_range(1, 3));
        if (k == 1) t = 64'hFFFF_FFFF_FFFF_FFFC;
        if (k == 2) t = 64'h0;
        return t;
    endfunction

    initial begin
        rst             = 1'b1;
        next_pc_i       = '0;
        next_pc_valid_i = 1'b0;
        inst_gnt_i      = 1'b0;
        inst_rvalid_i   = 1'b0;
        inst_rdata_i    = '0;
        inst_ready_i    = 1'b0;
        m_cnt           = '0;
        m_pc            = RST_PC;
        step();
        step();
        rst = 1'b0;
        check_eq("rst.valid", 64'(inst_valid_o), 64'd0);
        check_eq("rst.inst", 64'(inst_o), 64'(NOP));
        check_eq("rst.pc", pc_o, 64'd0);
        check_eq("rst.fault", 64'(fault_o), 64'd0);
        check_eq("rst.cnt", fetch_cnt_o, 64'd0);
        check_eq("rst.req", 64'(inst_req_o), 64'd1);

        do_fetch(0, 0, 0, 1'b1, 0, 64'h8000_0100, 1'b0);
        do_fetch(3, 0, 4, 1'b0, 5, 64'h8000_0100, 1'b0);
        do_fetch(0, 2, 1, 1'b1, 0, 64'h8000_0102, 1'b1);
        do_fetch(0, 0, 2, 1'b0, 3, 64'h8000_0200, 1'b1);

        for (int n = 0; n < 150; n++) begin
            do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'($urandom),
                     int'($urandom_range(0, 4)), rand_target(),
                     1'($urandom));
        end

        if (m_pc[1:0] != 2'b00) begin
            do_fetch(0, 0, 0, 1'b1, 0, 64'h8000_0040, 1'b0);
        end
        inst_gnt_i = 1'b1;
        step();
        inst_gnt_i = 1'b0;
        rst        = 1'b1;
        step();
        rst   = 1'b0;
        m_pc  = RST_PC;
        m_cnt = '0;
        check_eq("mrst.addr", inst_addr_o, RST_PC);
        check_eq("mrst.valid", 64'(inst_valid_o), 64'd0);
        check_eq("mrst.cnt", fetch_cnt_o, 64'd0);
        check_eq("mrst.req", 64'(inst_req_o), 64'd1);
        do_fetch(1, 1, 1, 1'b0, 2, 64'h8000_0004, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
